// File: rtl/id_ex_skid_reg_if.sv
// Bundle for the ID/EX skid register: decode-side handshake and payload,
// execute-side handshake and payload, back-pressure counter and FSM state.
//
// Handshake: a beat moves across a side on a rising edge exactly when valid
// and ready are both high there; a source raising valid keeps its payload
// stable until that edge, and ready never depends combinationally on valid.
interface id_ex_skid_reg_if #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5,
   parameter int OP_W   = 4,
   parameter int CNT_W  = 16
);
   // decode side
   logic              in_valid;
   logic              in_ready;
   logic [OP_W-1:0]   alu_opcode;
   logic              reg_flag;
   logic [RD_W-1:0]   rd;
   logic [DATA_W-1:0] rs1;
   logic [DATA_W-1:0] rs2;
   logic [DATA_W-1:0] immidiate_data;
   logic              reg_wr_en;
   logic              imm_sel;

   // execute side
   logic              out_valid;
   logic              out_ready;
   logic [OP_W-1:0]   alu_opout;
   logic              flag_out;
   logic [RD_W-1:0]   rd_out;
   logic [DATA_W-1:0] op1;
   logic [DATA_W-1:0] op2;
   logic [DATA_W-1:0] data;
   logic              reg_wr_en_out;

   // status
   logic [CNT_W-1:0]  stall_cnt;
   logic [1:0]        dbg_state;

   // Environment view: drives decode side, consumes execute side.
   modport master (
      output in_valid, alu_opcode, reg_flag, rd, rs1, rs2, immidiate_data,
             reg_wr_en, imm_sel, out_ready,
      input  in_ready, out_valid, alu_opout, flag_out, rd_out, op1, op2, data,
             reg_wr_en_out, stall_cnt, dbg_state
   );

   // Pipeline register view.
   modport slave (
      input  in_valid, alu_opcode, reg_flag, rd, rs1, rs2, immidiate_data,
             reg_wr_en, imm_sel, out_ready,
      output in_ready, out_valid, alu_opout, flag_out, rd_out, op1, op2, data,
             reg_wr_en_out, stall_cnt, dbg_state
   );
endinterface

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with a one-entry skid buffer.
// "main" drives the execute side; "skid" catches a beat accepted while the
// consumer stalls, so in_ready can come from a flop instead of out_ready.
// flush kills both entries; rst additionally clears payload and stall_cnt.
module id_ex_skid_reg #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5,
   parameter int OP_W   = 4,
   parameter int CNT_W  = 16
) (
   input logic             clk,
   input logic             rst,
   input logic             flush,
   id_ex_skid_reg_if.slave bus
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_in_ready;

   logic [OP_W-1:0]   r_main_op;
   logic              r_main_flag;
   logic [RD_W-1:0]   r_main_rd;
   logic [DATA_W-1:0] r_main_op1;
   logic [DATA_W-1:0] r_main_op2;
   logic [DATA_W-1:0] r_main_data;
   logic              r_main_wr;

   logic [OP_W-1:0]   r_skid_op;
   logic              r_skid_flag;
   logic [RD_W-1:0]   r_skid_rd;
   logic [DATA_W-1:0] r_skid_op1;
   logic [DATA_W-1:0] r_skid_op2;
   logic [DATA_W-1:0] r_skid_data;
   logic              r_skid_wr;

   logic [CNT_W-1:0]  r_stall_cnt;

   logic              w_main_valid;
   logic              w_skid_valid;
   logic              w_accept;
   logic              w_transfer;
   logic              w_load_main_in;
   logic              w_load_skid_in;
   logic              w_load_main_skid;
   logic [DATA_W-1:0] w_in_op2;
   logic              w_stall;

   // Valid bits follow directly from the state; skid-without-main cannot be encoded.
   assign w_main_valid = (r_state != S_EMPTY);
   assign w_skid_valid = (r_state == S_TWO);
   assign w_accept     = bus.in_valid & r_in_ready;
   assign w_transfer   = w_main_valid & bus.out_ready;
   assign w_in_op2     = bus.imm_sel ? bus.immidiate_data : bus.rs2;
   assign w_stall      = w_main_valid & ~bus.out_ready;

   // Next state and payload load selects; flush discards this cycle's moves.
   always_comb begin
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_skid_in   = 1'b0;
      w_load_main_skid = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_accept) begin
               w_state_nxt    = S_ONE;
               w_load_main_in = 1'b1;
            end
         end
         S_ONE: begin
            if (w_accept && w_transfer) begin
               w_load_main_in = 1'b1;
            end else if (w_accept) begin
               w_state_nxt    = S_TWO;
               w_load_skid_in = 1'b1;
            end else if (w_transfer) begin
               w_state_nxt    = S_EMPTY;
            end
         end
         S_TWO: begin
            if (w_transfer) begin
               w_state_nxt      = S_ONE;
               w_load_main_skid = 1'b1;
            end
         end
         default: w_state_nxt = S_EMPTY;
      endcase
      if (flush) begin
         w_state_nxt      = S_EMPTY;
         w_load_main_in   = 1'b0;
         w_load_skid_in   = 1'b0;
         w_load_main_skid = 1'b0;
      end
   end

   // State register; in_ready is registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != S_TWO);
      end
   end

   // Main entry: loads from the input or is refilled from skid.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_main_op   <= '0;
         r_main_flag <= 1'b0;
         r_main_rd   <= '0;
         r_main_op1  <= '0;
         r_main_op2  <= '0;
         r_main_data <= '0;
         r_main_wr   <= 1'b0;
      end else if (w_load_main_in) begin
         r_main_op   <= bus.alu_opcode;
         r_main_flag <= bus.reg_flag;
         r_main_rd   <= bus.rd;
         r_main_op1  <= bus.rs1;
         r_main_op2  <= w_in_op2;
         r_main_data <= bus.immidiate_data;
         r_main_wr   <= bus.reg_wr_en;
      end else if (w_load_main_skid) begin
         r_main_op   <= r_skid_op;
         r_main_flag <= r_skid_flag;
         r_main_rd   <= r_skid_rd;
         r_main_op1  <= r_skid_op1;
         r_main_op2  <= r_skid_op2;
         r_main_data <= r_skid_data;
         r_main_wr   <= r_skid_wr;
      end
   end

   // Skid entry: catches the beat accepted while main is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_skid_op   <= '0;
         r_skid_flag <= 1'b0;
         r_skid_rd   <= '0;
         r_skid_op1  <= '0;
         r_skid_op2  <= '0;
         r_skid_data <= '0;
         r_skid_wr   <= 1'b0;
      end else if (w_load_skid_in) begin
         r_skid_op   <= bus.alu_opcode;
         r_skid_flag <= bus.reg_flag;
         r_skid_rd   <= bus.rd;
         r_skid_op1  <= bus.rs1;
         r_skid_op2  <= w_in_op2;
         r_skid_data <= bus.immidiate_data;
         r_skid_wr   <= bus.reg_wr_en;
      end
   end

   // Saturating back-pressure counter; flush leaves it alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign bus.in_ready      = r_in_ready;
   assign bus.out_valid     = w_main_valid;
   assign bus.alu_opout     = r_main_op;
   assign bus.flag_out      = r_main_flag;
   assign bus.rd_out        = r_main_rd;
   assign bus.op1           = r_main_op1;
   assign bus.op2           = r_main_op2;
   assign bus.data          = r_main_data;
   // A bubble must never write the register file.
   assign bus.reg_wr_en_out = r_main_wr & w_main_valid;
   assign bus.stall_cnt     = r_stall_cnt;
   assign bus.dbg_state     = r_state;

   logic w_unused;
   assign w_unused = w_skid_valid;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Bench for id_ex_skid_reg: directed scenarios plus a FIFO scoreboard that
// records every accepted beat and compares it when the execute side takes it.
module tb_id_ex_skid_reg;

   localparam int PW = 128;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst;
   logic flush;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   id_ex_skid_reg_if #(.DATA_W(32), .RD_W(5), .OP_W(4), .CNT_W(16)) bus ();
   id_ex_skid_reg_if #(.DATA_W(32), .RD_W(5), .OP_W(4), .CNT_W(4))  bus4 ();

   id_ex_skid_reg #(.DATA_W(32), .RD_W(5), .OP_W(4), .CNT_W(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   id_ex_skid_reg #(.DATA_W(32), .RD_W(5), .OP_W(4), .CNT_W(4)) dut_sat (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus4)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [PW-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] pack_in();
      return {21'b0, bus.alu_opcode, bus.reg_flag, bus.rd, bus.rs1,
              (bus.imm_sel ? bus.immidiate_data : bus.rs2), bus.immidiate_data, bus.reg_wr_en};
   endfunction

   function automatic logic [PW-1:0] pack_out();
      return {21'b0, bus.alu_opout, bus.flag_out, bus.rd_out, bus.op1,
              bus.op2, bus.data, bus.reg_wr_en_out};
   endfunction

   // Scoreboard and stall-stability monitor, sampled mid-cycle.
   logic          prev_stall = 1'b0;
   logic [PW-1:0] prev_out   = '0;
   always @(negedge clk) begin
      logic [PW-1:0] e;
      if (rst || flush) begin
         exp_q.delete();
      end else begin
         if (prev_stall && bus.out_valid)
            chk("stall_hold", pack_out(), prev_out);
         if (bus.out_valid && bus.out_ready) begin
            chk("sb_nonempty", {127'b0, exp_q.size() != 0}, 128'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("sb_payload", pack_out(), e);
            end
         end
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(pack_in());
      end
      prev_stall = bus.out_valid && !bus.out_ready && !rst && !flush;
      prev_out   = pack_out();
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] rd_v, input logic wr, input logic sel);
      bus.in_valid       = v;
      bus.rd             = rd_v;
      bus.alu_opcode     = 4'($urandom_range(0, 15));
      bus.reg_flag       = 1'($urandom_range(0, 1));
      bus.rs1            = $urandom;
      bus.rs2            = $urandom;
      bus.immidiate_data = $urandom;
      bus.reg_wr_en      = wr;
      bus.imm_sel        = sel;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst   = 1'b1;
      flush = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 1'b0);
      bus.out_ready       = 1'b0;
      bus4.in_valid       = 1'b0;
      bus4.alu_opcode     = '0;
      bus4.reg_flag       = 1'b0;
      bus4.rd             = '0;
      bus4.rs1            = '0;
      bus4.rs2            = '0;
      bus4.immidiate_data = '0;
      bus4.reg_wr_en      = 1'b0;
      bus4.imm_sel        = 1'b0;
      bus4.out_ready      = 1'b0;
      repeat (2) cyc();
      rst = 1'b0;

      // reset state
      chk("rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
      chk("rst_in_ready", {127'b0, bus.in_ready}, 128'd1);
      chk("rst_wr_en_out", {127'b0, bus.reg_wr_en_out}, 128'd0);
      chk("rst_stall_cnt", {112'b0, bus.stall_cnt}, 128'd0);
      chk("rst_payload", pack_out(), 128'd0);

      // streaming: 8 back-to-back beats
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 5'(i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         cyc();
         chk("stream_rd", {123'b0, bus.rd_out}, 128'(i));
         chk("stream_valid", {127'b0, bus.out_valid}, 128'd1);
         chk("stream_in_ready", {127'b0, bus.in_ready}, 128'd1);
      end
      drive(1'b0, 5'd0, 1'b0, 1'b0);
      cyc();
      chk("stream_drain", {127'b0, bus.out_valid}, 128'd0);
      chk("stream_stall", {112'b0, bus.stall_cnt}, 128'd0);

      // skid fill with the consumer stalled
      bus.out_ready = 1'b0;
      drive(1'b1, 5'd3, 1'b1, 1'b0);
      cyc();
      chk("skid_ready1", {127'b0, bus.in_ready}, 128'd1);
      drive(1'b1, 5'd4, 1'b0, 1'b1);
      cyc();
      drive(1'b0, 5'd0, 1'b0, 1'b0);
      chk("skid_in_ready", {127'b0, bus.in_ready}, 128'd0);
      chk("skid_rd3", {123'b0, bus.rd_out}, 128'd3);
      chk("skid_stall1", {112'b0, bus.stall_cnt}, 128'd1);
      repeat (5) cyc();
      chk("skid_stall6", {112'b0, bus.stall_cnt}, 128'd6);
      chk("skid_rd3_held", {123'b0, bus.rd_out}, 128'd3);
      bus.out_ready = 1'b1;
      cyc();
      chk("skid_rd4", {123'b0, bus.rd_out}, 128'd4);
      chk("skid_valid4", {127'b0, bus.out_valid}, 128'd1);
      chk("skid_ready_back", {127'b0, bus.in_ready}, 128'd1);
      cyc();
      chk("skid_empty", {127'b0, bus.out_valid}, 128'd0);

      // immediate select
      drive(1'b1, 5'd12, 1'b1, 1'b1);
      bus.rs2            = 32'h0000_0011;
      bus.immidiate_data = 32'hFFFF_FFF0;
      cyc();
      chk("imm_op2", {96'b0, bus.op2}, 128'hFFFF_FFF0);
      chk("imm_data", {96'b0, bus.data}, 128'hFFFF_FFF0);
      bus.imm_sel = 1'b0;
      cyc();
      chk("rs2_op2", {96'b0, bus.op2}, 128'h0000_0011);
      chk("rs2_data", {96'b0, bus.data}, 128'hFFFF_FFF0);
      drive(1'b0, 5'd0, 1'b0, 1'b0);
      cyc();

      // flush in state TWO together with an incoming beat
      bus.out_ready = 1'b0;
      drive(1'b1, 5'd5, 1'b1, 1'b0);
      cyc();
      drive(1'b1, 5'd6, 1'b1, 1'b0);
      cyc();
      chk("fl_wr_en_before", {127'b0, bus.reg_wr_en_out}, 128'd1);
      drive(1'b1, 5'd7, 1'b1, 1'b0);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 1'b0);
      chk("fl_out_valid", {127'b0, bus.out_valid}, 128'd0);
      chk("fl_wr_en_out", {127'b0, bus.reg_wr_en_out}, 128'd0);
      chk("fl_in_ready", {127'b0, bus.in_ready}, 128'd1);
      chk("fl_stall8", {112'b0, bus.stall_cnt}, 128'd8);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("fl_no_ghost", {127'b0, bus.out_valid}, 128'd0);
      end
      // flush also discards an accept made from EMPTY
      drive(1'b1, 5'd8, 1'b1, 1'b0);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 1'b0);
      chk("fl_empty_accept", {127'b0, bus.out_valid}, 128'd0);

      // reset beats flush in state TWO
      bus.out_ready = 1'b0;
      drive(1'b1, 5'd9, 1'b1, 1'b0);
      cyc();
      drive(1'b1, 5'd10, 1'b1, 1'b1);
      cyc();
      chk("rp_stall9", {112'b0, bus.stall_cnt}, 128'd9);
      chk("rp_state_two", {126'b0, bus.dbg_state}, 128'd2);
      drive(1'b1, 5'd11, 1'b1, 1'b0);
      rst   = 1'b1;
      flush = 1'b1;
      cyc();
      rst   = 1'b0;
      flush = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 1'b0);
      chk("rp_payload", pack_out(), 128'd0);
      chk("rp_out_valid", {127'b0, bus.out_valid}, 128'd0);
      chk("rp_stall0", {112'b0, bus.stall_cnt}, 128'd0);
      chk("rp_in_ready", {127'b0, bus.in_ready}, 128'd1);
      bus.out_ready = 1'b1;
      repeat (2) cyc();
      chk("rp_discarded", {127'b0, bus.out_valid}, 128'd0);

      // saturation on the 4-bit counter instance
      bus4.in_valid  = 1'b1;
      bus4.rd        = 5'd1;
      bus4.out_ready = 1'b0;
      cyc();
      bus4.in_valid = 1'b0;
      repeat (14) cyc();
      chk("sat_14", {124'b0, bus4.stall_cnt}, 128'd14);
      cyc();
      chk("sat_15", {124'b0, bus4.stall_cnt}, 128'd15);
      repeat (5) cyc();
      chk("sat_20", {124'b0, bus4.stall_cnt}, 128'd15);
      repeat (3) cyc();
      chk("sat_held", {124'b0, bus4.stall_cnt}, 128'd15);

      chk("sb_drain", 128'(exp_q.size()), 128'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/id_ex_skid_reg.md
ID_EX_SKID_REG -- requirements
Module: id_ex_skid_reg

Interface
REQ-001 The module SHALL have the parameter DATA_W, default 32, the operand and immediate width.
REQ-002 The module SHALL have the parameter RD_W, default 5, the destination-register index width.
REQ-003 The module SHALL have the parameter OP_W, default 4, the ALU opcode width.
REQ-004 The module SHALL have the parameter CNT_W, default 16, the stall-counter width.
REQ-005 The module SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The module SHALL have the port rst, input, 1 bit; reset is synchronous and active-high.
REQ-007 The module SHALL have the port flush, input, 1 bit, a synchronous pipeline kill.
REQ-008 The module SHALL have the ports in_valid (input, 1 bit) and in_ready (output, 1 bit), the decode-side handshake.
REQ-009 The module SHALL have the ports alu_opcode (input, OP_W), reg_flag (input, 1), rd (input, RD_W), rs1 (input, DATA_W), rs2 (input, DATA_W), immidiate_data (input, DATA_W), reg_wr_en (input, 1) and imm_sel (input, 1); imm_sel selects the immediate as operand 2.
REQ-010 The module SHALL have the ports out_valid (output, 1 bit) and out_ready (input, 1 bit), the execute-side handshake.
REQ-011 The module SHALL have the outputs alu_opout (OP_W), flag_out (1), rd_out (RD_W), op1 (DATA_W), op2 (DATA_W), data (DATA_W) and reg_wr_en_out (1).
REQ-012 The module SHALL have the output stall_cnt, CNT_W bits, counting back-pressure cycles.

Function
REQ-013 Storage SHALL be two payload entries: main, which drives the outputs, and skid. Each entry SHALL have a valid bit.
REQ-014 The state SHALL be EMPTY (neither entry valid), ONE (main valid) or TWO (main and skid valid). The combination of skid valid with main invalid SHALL be illegal.
REQ-015 Port relationships SHALL be as follows:
- out_valid = main valid.
- in_ready = NOT skid valid, taken from a register with no combinational path from out_ready.
REQ-016 Handshake events SHALL be defined as accept = in_valid AND in_ready, and transfer = out_valid AND out_ready.
REQ-017 Payload SHALL be captured at accept as: alu_opcode, reg_flag, rd, rs1 into op1, op2 = (imm_sel ? immidiate_data : rs2), immidiate_data into data, reg_wr_en.
REQ-018 State transitions SHALL be:
- EMPTY: accept -> ONE, input loaded into main.
- ONE: accept with transfer -> ONE, input into main.
- ONE: accept without transfer -> TWO, input into skid.
- ONE: transfer without accept -> EMPTY.
- ONE: neither -> hold.
- TWO: transfer -> ONE, skid copied into main.
- TWO: no transfer -> hold.
REQ-019 Accept SHALL NOT be possible in TWO, because in_ready = 0.
REQ-020 Latency SHALL be 1 cycle: data accepted in EMPTY, or in ONE with transfer, SHALL appear at the outputs with out_valid = 1 on the next cycle.
REQ-021 Throughput SHALL be one transfer per cycle when out_ready is held at 1.
REQ-022 Ordering SHALL be strict FIFO: no entry is reordered, duplicated or dropped except by flush or rst.
REQ-023 While an output is stalled (out_valid = 1, out_ready = 0), all outputs SHALL hold stable.
REQ-024 reg_wr_en_out SHALL equal main.reg_wr_en AND out_valid, so that a bubble never writes the register file.
REQ-025 When flush = 1 and rst = 0, at the next edge:
- Both valid bits SHALL clear and the state SHALL go to EMPTY.
- Any accept or transfer in that cycle SHALL be discarded.
- Payload registers MAY retain their values.
REQ-026 On the cycle after a flush, in_ready SHALL be 1.
REQ-027 stall_cnt SHALL increment by 1 on each cycle with out_valid = 1 and out_ready = 0, SHALL saturate at 2^CNT_W - 1, and SHALL be unaffected by flush.
REQ-028 All arithmetic SHALL be unsigned, with no width extension or truncation of the payload.

Reset
REQ-029 When rst = 1 at a rising edge, the following SHALL apply:
- Both valid bits are 0 and the state is EMPTY.
- All payload outputs are 0.
- stall_cnt is 0.
REQ-030 During the cycle after a reset, out_valid and reg_wr_en_out SHALL be 0 and in_ready SHALL be 1.
REQ-031 rst SHALL take priority over flush and over all handshake activity.
REQ-032 A reset asserted mid-operation (in state TWO) SHALL discard both entries.

Verification
REQ-033 Streaming: the bench SHALL drive out_ready = 1 with 8 back-to-back accepts of rd = 1..8 -> outputs rd_out = 1..8 on consecutive cycles starting 1 cycle after the first accept, with in_ready constantly 1 and stall_cnt = 0.
REQ-034 Skid fill: the bench SHALL accept rd = 3 and then rd = 4 with out_ready = 0 -> in_ready = 0 afterwards and rd_out = 3 held; after 5 stalled cycles stall_cnt = 6; raising out_ready -> rd_out = 4 next cycle, then out_valid = 0.
REQ-035 Immediate select: the bench SHALL drive rs2 = 0x0000_0011, immidiate_data = 0xFFFF_FFF0, imm_sel = 1 -> op2 = 0xFFFF_FFF0 and data = 0xFFFF_FFF0; with imm_sel = 0 -> op2 = 0x0000_0011.
REQ-036 Flush: the bench SHALL fill state TWO with reg_wr_en = 1 and assert flush together with in_valid -> next cycle out_valid = 0, reg_wr_en_out = 0 and in_ready = 1, with the flushed-cycle input never appearing at the outputs.
REQ-037 Reset priority: the bench SHALL assert rst and flush together in state TWO while stall_cnt = 9 -> next cycle all outputs are 0, stall_cnt = 0 and in_ready = 1.
REQ-038 Saturation: with CNT_W = 4, the bench SHALL stall for 20 cycles -> stall_cnt = 15 and held.
